// File: rtl/fetcher_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The fetcher's optional prediction path is controlled by FETCHER_PREDICT_EN
// (see fetcher.sv); nothing in this package depends on it.
package fetcher_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int INS_WIDTH  = 32;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [INS_WIDTH-1:0]  ins_t;

    localparam addr_t ZERO_ADDR = '0;

    // Bit range of the opcode field inside an instruction word
    localparam int OPCODE_HI = 6;
    localparam int OPCODE_LO = 0;

    // One instruction-queue slot: the word, where it came from, and its prediction
    typedef struct packed {
        ins_t  inst;
        addr_t pc;
        logic  predicted_jump;
    } iq_entry_t;

    localparam int IQ_ENTRY_WIDTH = $bits(iq_entry_t);

    // Fetch FSM encodings
    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_WAIT    = 2'd1;
    localparam logic [1:0] STATE_DISCARD = 2'd2;

    // Next sequential or predicted PC; the predictor supplies a PC-relative offset
    function automatic addr_t next_pc(input addr_t pc, input logic jump, input addr_t offset);
        return jump ? (pc + offset) : (pc + addr_t'(4));
    endfunction

endpackage

// File: rtl/fetcher_inst_queue.sv
// Circular instruction queue between fetch and dispatch.
// Push, pop and clear are honoured only while rdy is high; clear wins over both.
module inst_queue
    import fetcher_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = IQ_ENTRY_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   clear,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   near_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && !clear;
    assign do_pop    = pop && !clear && !empty;
    assign empty     = (count == '0);
    assign near_full = (count >= CNT_W'(DEPTH - 1));
    // An empty queue presents zeros so the consumer sees a clean head
    assign head_data = empty ? '0 : slots[head];

    // Pointer and occupancy bookkeeping; a flush empties the queue outright
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_push) tail <= tail + PTR_W'(1);
                if (do_pop)  head <= head + PTR_W'(1);
                count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
            end
        end
    end

    // Slot storage; contents need no reset because count guards every read
    always_ff @(posedge clk) begin
        if (rdy && do_push) begin
            slots[tail] <= push_data;
        end
    end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: owns the PC, keeps one memory read in flight,
// steers the next PC with the predictor and buffers words for dispatch.
// Define FETCHER_PREDICT_EN to honour predictor results; otherwise the next
// PC is always pc+4 and queued prediction bits are zero.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int    IQ_DEPTH = 16,
    parameter addr_t RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_pc,
    input  logic        mem_ack,
    input  logic [31:0] mem_inst,
    output logic [31:0] query_pc,
    output logic [31:0] query_inst,
    input  logic        predicted_jump,
    input  logic [31:0] predicted_target_pc,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_predicted_jump,
    input  logic        out_ready,
    input  logic        rollback,
    input  logic [31:0] rollback_pc
);

    localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

    logic [1:0]       state;
    addr_t            pc;
    addr_t            req_pc;
    logic             take_jump;
    addr_t            jump_offset;
    logic             push;
    logic             pop;
    logic             can_issue;
    iq_entry_t        push_entry;
    iq_entry_t        head_entry;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             near_full;

`ifdef FETCHER_PREDICT_EN
    assign take_jump   = predicted_jump;
    assign jump_offset = predicted_target_pc;
`else
    logic unused_predictor;
    assign take_jump        = 1'b0;
    assign jump_offset      = ZERO_ADDR;
    assign unused_predictor = ^{predicted_jump, predicted_target_pc};
`endif

    assign mem_req_valid = (state == STATE_WAIT);
    assign mem_req_pc    = req_pc;
    assign query_pc      = req_pc;
    assign query_inst    = mem_inst;

    assign out_valid          = !empty;
    assign out_inst           = head_entry.inst;
    assign out_pc             = head_entry.pc;
    assign out_predicted_jump = head_entry.predicted_jump;

    assign pop        = out_valid && out_ready;
    assign push       = (state == STATE_WAIT) && mem_ack && !rollback;
    assign push_entry = '{inst: mem_inst, pc: pc, predicted_jump: take_jump};
    // Keep one slot free so the word coming back always has room
    assign can_issue  = !near_full || ((count == CNT_W'(IQ_DEPTH - 1)) && pop);

    inst_queue #(
        .DEPTH (IQ_DEPTH),
        .WIDTH (IQ_ENTRY_WIDTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (rollback),
        .head_data (head_entry),
        .count     (count),
        .empty     (empty),
        .near_full (near_full)
    );

    // Fetch FSM and PC update; rollback overrides everything and drops any ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= STATE_IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else if (rdy) begin
            if (rollback) begin
                pc <= rollback_pc;
                case (state)
                    STATE_WAIT:    state <= mem_ack ? STATE_IDLE : STATE_DISCARD;
                    STATE_DISCARD: state <= mem_ack ? STATE_IDLE : STATE_DISCARD;
                    default:       state <= STATE_IDLE;
                endcase
            end else begin
                case (state)
                    STATE_IDLE: begin
                        if (can_issue) begin
                            req_pc <= pc;
                            state  <= STATE_WAIT;
                        end
                    end
                    STATE_WAIT: begin
                        if (mem_ack) begin
                            pc    <= next_pc(pc, take_jump, jump_offset);
                            state <= STATE_IDLE;
                        end
                    end
                    STATE_DISCARD: begin
                        if (mem_ack) state <= STATE_IDLE;
                    end
                    default: state <= STATE_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for the fetcher: directed vector table, hand-written
// flush/backpressure sequences, then randomized traffic against a model.
module tb_fetcher;

    localparam int DEPTH = 8;
`ifdef FETCHER_PREDICT_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        mem_req_valid;
    logic [31:0] mem_req_pc;
    logic        mem_ack;
    logic [31:0] mem_inst;
    logic [31:0] query_pc;
    logic [31:0] query_inst;
    logic        predicted_jump;
    logic [31:0] predicted_target_pc;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_predicted_jump;
    logic        out_ready;
    logic        rollback;
    logic [31:0] rollback_pc;

    int num_checks = 0;
    int num_fails  = 0;

    typedef struct {
        string       name;
        logic [31:0] start_pc;
        logic [31:0] inst;
        logic        exp_jump;
        logic [31:0] exp_next;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pj;
    } ent_t;

    vec_t vecs [5];
    ent_t mq [$];

    fetcher #(
        .IQ_DEPTH (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .mem_req_valid       (mem_req_valid),
        .mem_req_pc          (mem_req_pc),
        .mem_ack             (mem_ack),
        .mem_inst            (mem_inst),
        .query_pc            (query_pc),
        .query_inst          (query_inst),
        .predicted_jump      (predicted_jump),
        .predicted_target_pc (predicted_target_pc),
        .out_valid           (out_valid),
        .out_inst            (out_inst),
        .out_pc              (out_pc),
        .out_predicted_jump  (out_predicted_jump),
        .out_ready           (out_ready),
        .rollback            (rollback),
        .rollback_pc         (rollback_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // J-type immediate decode of a JAL word
    function automatic logic [31:0] jalOffset(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Predictor stand-in: predicts every JAL taken with its encoded offset
    always_comb begin
        predicted_jump      = (query_inst[6:0] == 7'h6F);
        predicted_target_pc = jalOffset(query_inst);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ack, input logic [31:0] inst, input logic rb,
                                 input logic [31:0] rbpc, input logic ordy);
        mem_ack     = ack;
        mem_inst    = inst;
        rollback    = rb;
        rollback_pc = rbpc;
        out_ready   = ordy;
        tick();
        mem_ack   = 1'b0;
        rollback  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic waitReq(input string name);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            n++;
        end
        checkOutput({name, " request timeout"}, 32'(mem_req_valid), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          acks;
        int          lat;
        bit          outstanding;
        bit          discarding;
        bit          prev_valid;
        logic        r, ack, rb, ordy, pj;
        logic [31:0] inst, rbpc, mpc, off;

        vecs[0] = '{"nop at 0",      32'h0000_0000, 32'h0000_0013, 1'b0,    32'h0000_0004};
        vecs[1] = '{"jal +8 at 10",  32'h0000_0010, 32'h0080_006F, PRED_EN, PRED_EN ? 32'h18 : 32'h14};
        vecs[2] = '{"jal +8 at 20",  32'h0000_0020, 32'h0080_006F, PRED_EN, PRED_EN ? 32'h28 : 32'h24};
        vecs[3] = '{"jal -4 at 100", 32'h0000_0100, 32'hFFDF_F06F, PRED_EN, PRED_EN ? 32'hFC : 32'h104};
        vecs[4] = '{"nop wrap",      32'hFFFF_FFFC, 32'h0000_0013, 1'b0,    32'h0000_0000};

        rst = 1'b1; rdy = 1'b1; mem_ack = 1'b0; mem_inst = '0;
        rollback = 1'b0; rollback_pc = '0; out_ready = 1'b0;
        tick();
        tick();
        checkOutput("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_inst", out_inst, 32'd0);
        checkOutput("reset out_pc", out_pc, 32'd0);
        checkOutput("reset out_predicted_jump", 32'(out_predicted_jump), 32'd0);
        rst = 1'b0;

        // First fetch straight out of reset
        tick();
        checkOutput("first req valid", 32'(mem_req_valid), 32'd1);
        checkOutput("first req pc", mem_req_pc, 32'h0);
        applyStimulus(1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
        checkOutput("first out_valid", 32'(out_valid), 32'd1);
        checkOutput("first out_pc", out_pc, 32'h0);
        checkOutput("first out_inst", out_inst, 32'h0000_0013);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("first next req valid", 32'(mem_req_valid), 32'd1);
        checkOutput("first next req pc", mem_req_pc, 32'h4);
        checkOutput("first popped", 32'(out_valid), 32'd0);

        // Vector table: redirect via rollback+ack, fetch one word, check the steering
        for (int i = 0; i < 5; i++) begin
            waitReq(vecs[i].name);
            applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, vecs[i].start_pc, 1'b0);
            checkOutput({vecs[i].name, " rb+ack not pushed"}, 32'(out_valid), 32'd0);
            checkOutput({vecs[i].name, " rb+ack idle"}, 32'(mem_req_valid), 32'd0);
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            checkOutput({vecs[i].name, " req valid"}, 32'(mem_req_valid), 32'd1);
            checkOutput({vecs[i].name, " req pc"}, mem_req_pc, vecs[i].start_pc);
            applyStimulus(1'b1, vecs[i].inst, 1'b0, 32'h0, 1'b0);
            checkOutput({vecs[i].name, " out_valid"}, 32'(out_valid), 32'd1);
            checkOutput({vecs[i].name, " out_inst"}, out_inst, vecs[i].inst);
            checkOutput({vecs[i].name, " out_pc"}, out_pc, vecs[i].start_pc);
            checkOutput({vecs[i].name, " out_pj"}, 32'(out_predicted_jump), 32'(vecs[i].exp_jump));
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            checkOutput({vecs[i].name, " next req valid"}, 32'(mem_req_valid), 32'd1);
            checkOutput({vecs[i].name, " next req pc"}, mem_req_pc, vecs[i].exp_next);
            checkOutput({vecs[i].name, " popped"}, 32'(out_valid), 32'd0);
        end

        // Rollback while waiting: the late ack must be swallowed
        waitReq("discard");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b0);
        checkOutput("discard no req", 32'(mem_req_valid), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("discard holds for ack", 32'(mem_req_valid), 32'd0);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        checkOutput("discard ack dropped", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("discard restart valid", 32'(mem_req_valid), 32'd1);
        checkOutput("discard restart pc", mem_req_pc, 32'h0000_0100);

        // Backpressure: fill with out_ready low, then drain and check order
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0200, 1'b0);
        acks = 0;
        for (int i = 0; i < 100; i++) begin
            if (mem_req_valid) begin
                checkOutput("fill req pc", mem_req_pc, 32'h200 + 32'(4 * acks));
                applyStimulus(1'b1, 32'h13 | (32'(acks) << 7), 1'b0, 32'h0, 1'b0);
                acks++;
            end else begin
                applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            end
        end
        checkOutput("fill entries", 32'(acks), 32'(DEPTH - 1));
        checkOutput("fill stalled", 32'(mem_req_valid), 32'd0);
        for (int k = 0; k < DEPTH - 1; k++) begin
            checkOutput("drain valid", 32'(out_valid), 32'd1);
            checkOutput("drain pc", out_pc, 32'h200 + 32'(4 * k));
            checkOutput("drain inst", out_inst, 32'h13 | (32'(k) << 7));
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        end
        checkOutput("drain empty", 32'(out_valid), 32'd0);

        // Randomized traffic against the reference model
        waitReq("random start");
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_1000, 1'b0);
        mq.delete();
        mpc = 32'h0000_1000;
        outstanding = 1'b0;
        discarding  = 1'b0;
        prev_valid  = 1'b0;
        lat = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checkOutput("rand out_valid", 32'(out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                checkOutput("rand out_inst", out_inst, mq[0].inst);
                checkOutput("rand out_pc", out_pc, mq[0].pc);
                checkOutput("rand out_pj", 32'(out_predicted_jump), 32'(mq[0].pj));
            end
            if (discarding) checkOutput("rand discard no req", 32'(mem_req_valid), 32'd0);
            else if (mem_req_valid) checkOutput("rand req pc", mem_req_pc, mpc);
            if (mem_req_valid && !prev_valid)
                checkOutput("rand issue slack", 32'(mq.size() <= DEPTH - 2), 32'd1);
            prev_valid = mem_req_valid;
            if (!outstanding && mem_req_valid) begin
                outstanding = 1'b1;
                lat = int'($urandom_range(0, 3));
            end

            r    = ($urandom_range(0, 7) != 0);
            ordy = 1'($urandom_range(0, 1));
            ack  = 1'b0;
            rb   = 1'b0;
            if (r) begin
                rb = ($urandom_range(0, 39) == 0);
                if (outstanding) begin
                    if (lat == 0) ack = 1'b1;
                    else lat--;
                end
            end
            if ($urandom_range(0, 1) == 1) inst = ($urandom() & 32'hFFFF_FF80) | 32'h6F;
            else inst = ($urandom() & 32'hFFFF_FF80) | 32'h33;
            rbpc = $urandom() & 32'hFFFF_FFFC;
            pj   = PRED_EN && (inst[6:0] == 7'h6F);
            off  = jalOffset(inst);

            if (r) begin
                if (rb) begin
                    mq.delete();
                    mpc = rbpc;
                    discarding = outstanding && !ack;
                end else begin
                    if (mq.size() != 0 && ordy) mq.delete(0);
                    if (ack) begin
                        if (discarding) begin
                            discarding = 1'b0;
                        end else begin
                            mq.push_back('{inst, mpc, pj});
                            mpc = pj ? mpc + off : mpc + 32'd4;
                        end
                    end
                end
                if (ack) outstanding = 1'b0;
            end

            rdy = r;
            applyStimulus(ack, inst, rb, rbpc, ordy);
        end
        rdy = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
